rtc_bus_driver: RTL

Downstream bus stage of the RTC sequencing FSM. It takes one transaction request (address, read/write, write data) and generates the multiplexed address/data bus cycle toward the RTC chip: cs_n, rd_n, wr_n, ad_n and a tri-state AD byte. Each phase has a programmable clock-count width. Read data is sampled and returned with a one-cycle done pulse.

---
 rtl/rtc_bus_pkg.sv | 25 ++
 rtl/rtc_phase_timer.sv | 24 ++
 rtl/rtc_bus_driver.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/rtc_bus_pkg.sv
// rtc_bus_pkg: shared state encoding, default timing and read/write codes for the RTC bus driver
package rtc_bus_pkg;

  typedef enum logic [3:0] {
    IDLE,
    A_SETUP,
    A_STROBE,
    A_HOLD,
    D_SETUP,
    D_STROBE,
    D_HOLD,
    DONE,
    TURN
  } state_t;

  localparam int T_SETUP_DEF = 2;
  localparam int T_PULSE_DEF = 6;
  localparam int T_HOLD_DEF  = 2;
  localparam int T_TURN_DEF  = 4;
  localparam int CNT_W_DEF   = 4;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/rtc_phase_timer.sv
// rtc_phase_timer: phase cycle counter with sync load and terminal count against a phase length
//   clk, clr  : clock, asynchronous active-high reset
//   i_load    : restart counting from 0 on the next edge
//   i_len     : current phase length in cycles (>= 1)
//   o_tc      : high on the last cycle of the phase (count == len-1)
module rtc_phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             i_load,
  input  logic [CNT_W:0]   i_len,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge clr)
    if (clr) r_cnt <= '0;
    else     r_cnt <= i_load ? '0 : r_cnt + 1'b1;

  assign o_tc = {1'b0, r_cnt} == i_len - 1'b1;

endmodule

// File: rtl/rtc_bus_driver.sv
// rtc_bus_driver: multiplexed address/data bus cycle generator toward the RTC chip
//   clk, clr            : clock, asynchronous active-high reset
//   start, rw, addr,
//   wdata               : transaction request, latched only in IDLE (rw 1 = read)
//   rdata, done, busy   : read result, one-cycle completion pulse, not-idle flag
//   cs_n, rd_n, wr_n,
//   ad_n                : bus strobes (ad_n 0 = address phase, 1 = data phase)
//   ad_out, ad_oe, ad_in: AD byte out, tri-state enable, AD readback
// Build option: RTC_BUS_TURNAROUND_EN adds a T_TURN-cycle recovery state after DONE.
module rtc_bus_driver
  import rtc_bus_pkg::*;
#(
  parameter int T_SETUP = T_SETUP_DEF,
  parameter int T_PULSE = T_PULSE_DEF,
  parameter int T_HOLD  = T_HOLD_DEF,
  parameter int T_TURN  = T_TURN_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       ad_n,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in
);

  localparam logic [CNT_W:0] L_SETUP = (CNT_W+1)'(T_SETUP);
  localparam logic [CNT_W:0] L_PULSE = (CNT_W+1)'(T_PULSE);
  localparam logic [CNT_W:0] L_HOLD  = (CNT_W+1)'(T_HOLD);
  localparam logic [CNT_W:0] L_TURN  = (CNT_W+1)'(T_TURN);

  state_t       r_state, w_next;
  logic         r_rw;
  logic [7:0]   r_addr, r_wdata, r_rdata, r_ad_out;
  logic         r_busy, r_done, r_cs_n, r_rd_n, r_wr_n, r_ad_n, r_ad_oe;
  logic         w_rw, w_aph, w_dph, w_wr_data, w_tc;
  logic [7:0]   w_addr, w_wdata, w_ad_out;
  logic         w_busy, w_done, w_cs_n, w_rd_n, w_wr_n, w_ad_n, w_ad_oe;
  logic [CNT_W:0] w_len;

  // IDLE, DONE and TURN share the turnaround length; only TURN ever waits on it
  always_comb
    w_len = (r_state == A_SETUP  || r_state == D_SETUP)  ? L_SETUP :
            (r_state == A_STROBE || r_state == D_STROBE) ? L_PULSE :
            (r_state == A_HOLD   || r_state == D_HOLD)   ? L_HOLD  : L_TURN;

  rtc_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .clr    (clr),
    .i_load (w_next != r_state),
    .i_len  (w_len),
    .o_tc   (w_tc)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = start ? A_SETUP : IDLE;
      A_SETUP:  w_next = w_tc ? A_STROBE : A_SETUP;
      A_STROBE: w_next = w_tc ? A_HOLD   : A_STROBE;
      A_HOLD:   w_next = w_tc ? D_SETUP  : A_HOLD;
      D_SETUP:  w_next = w_tc ? D_STROBE : D_SETUP;
      D_STROBE: w_next = w_tc ? D_HOLD   : D_STROBE;
      D_HOLD:   w_next = w_tc ? DONE     : D_HOLD;
`ifdef RTC_BUS_TURNAROUND_EN
      DONE:     w_next = TURN;
      TURN:     w_next = w_tc ? IDLE : TURN;
`else
      DONE:     w_next = IDLE;
`endif
      default:  w_next = IDLE;
    endcase
  end

  // Pins are registered from the next state; while leaving IDLE the request
  // fields are taken straight from the inputs being latched on the same edge.
  always_comb begin
    w_rw      = (r_state == IDLE) ? rw    : r_rw;
    w_addr    = (r_state == IDLE) ? addr  : r_addr;
    w_wdata   = (r_state == IDLE) ? wdata : r_wdata;
    w_aph     = w_next == A_SETUP || w_next == A_STROBE || w_next == A_HOLD;
    w_dph     = w_next == D_SETUP || w_next == D_STROBE || w_next == D_HOLD;
    w_wr_data = w_dph && w_rw == RW_WRITE;
    w_cs_n    = !(w_next == A_STROBE || w_next == D_STROBE);
    w_wr_n    = !(w_next == A_STROBE || (w_next == D_STROBE && w_rw == RW_WRITE));
    w_rd_n    = !(w_next == D_STROBE && w_rw == RW_READ);
    w_ad_n    = !w_aph;
    w_ad_oe   = w_aph || w_wr_data;
    w_ad_out  = w_aph ? w_addr : w_wr_data ? w_wdata : 8'h00;
    w_busy    = w_next != IDLE;
    w_done    = w_next == DONE;
  end

  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      r_state  <= IDLE;
      r_rw     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cs_n   <= 1'b1;
      r_rd_n   <= 1'b1;
      r_wr_n   <= 1'b1;
      r_ad_n   <= 1'b1;
      r_ad_oe  <= 1'b0;
      r_ad_out <= '0;
    end else begin
      r_state  <= w_next;
      if (r_state == IDLE && start) begin
        r_rw    <= rw;
        r_addr  <= addr;
        r_wdata <= wdata;
      end
      if (r_state == D_STROBE && w_tc && r_rw == RW_READ) r_rdata <= ad_in;
      r_busy   <= w_busy;
      r_done   <= w_done;
      r_cs_n   <= w_cs_n;
      r_rd_n   <= w_rd_n;
      r_wr_n   <= w_wr_n;
      r_ad_n   <= w_ad_n;
      r_ad_oe  <= w_ad_oe;
      r_ad_out <= w_ad_out;
    end

  assign rdata  = r_rdata;
  assign busy   = r_busy;
  assign done   = r_done;
  assign cs_n   = r_cs_n;
  assign rd_n   = r_rd_n;
  assign wr_n   = r_wr_n;
  assign ad_n   = r_ad_n;
  assign ad_oe  = r_ad_oe;
  assign ad_out = r_ad_out;

endmodule
